// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} arb_owner_e;

  typedef struct packed {
    arb_owner_e  owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } arb_req_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between fetch (I) and data (D) requesters, with a counter that
// bounds how many D grants in a row may pass over a waiting I request.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_arb_en,
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_gnt_i,
  output logic o_gnt_d
);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [SW-1:0] r_starve_cnt;
  logic          w_starved;

  assign w_starved = (r_starve_cnt >= SW'(STARVE_MAX));
  assign o_gnt_d   = i_arb_en & i_dreq & (~i_ireq | ~w_starved);
  assign o_gnt_i   = i_arb_en & i_ireq & ~o_gnt_d;

  // Counts only D grants that bypassed a pending fetch; any other grant clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (o_gnt_d && i_ireq) begin
      if (!w_starved) r_starve_cnt <= r_starve_cnt + SW'(1);
    end else if (o_gnt_d || o_gnt_i) begin
      r_starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core's fetch (I) and data (D) ports.
// Every access runs IDLE -> ISSUE -> WAIT -> RESP; all outputs are registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          STARVE_MAX = 2,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_done,
  output logic        bus_err
);
  localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  arb_state_e    r_state, w_state_nxt;
  arb_req_t      r_req, w_req_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_nxt;
  logic          r_m_en, r_i_ack, r_d_ack, r_bus_err;
  logic          w_m_en_nxt, w_i_ack_nxt, w_d_ack_nxt, w_bus_err_nxt;
  logic [31:0]   r_i_rdata, r_d_rdata, w_i_rdata_nxt, w_d_rdata_nxt;
  logic [31:0]   w_resp_data;
  logic          w_arb_en, w_gnt_i, w_gnt_d;

  assign w_arb_en    = (r_state == IDLE);
  assign w_resp_data = m_done ? m_rdata : ERR_DATA;

  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk      (clk),
    .reset    (reset),
    .i_arb_en (w_arb_en),
    .i_ireq   (i_req),
    .i_dreq   (d_req),
    .o_gnt_i  (w_gnt_i),
    .o_gnt_d  (w_gnt_d)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_req;
    w_wait_nxt    = r_wait_cnt;
    w_m_en_nxt    = 1'b0;
    w_i_ack_nxt   = 1'b0;
    w_d_ack_nxt   = 1'b0;
    w_bus_err_nxt = 1'b0;
    w_i_rdata_nxt = r_i_rdata;
    w_d_rdata_nxt = r_d_rdata;
    case (r_state)
      IDLE: begin
        if (w_gnt_d) begin
          w_req_nxt   = '{owner: OWN_D, we: d_we, addr: d_addr, wdata: d_wdata};
          w_state_nxt = ISSUE;
          w_m_en_nxt  = 1'b1;
        end else if (w_gnt_i) begin
          w_req_nxt   = '{owner: OWN_I, we: 1'b0, addr: i_addr, wdata: '0};
          w_state_nxt = ISSUE;
          w_m_en_nxt  = 1'b1;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
        w_wait_nxt  = '0;
      end
      WAIT: begin
        // m_done takes precedence over an expiring timeout in the same cycle.
        if (m_done || (r_wait_cnt == WAIT_LAST)) begin
          w_state_nxt   = RESP;
          w_bus_err_nxt = ~m_done;
          if (r_req.owner == OWN_D) begin
            w_d_ack_nxt = 1'b1;
            if (!r_req.we) w_d_rdata_nxt = w_resp_data;
          end else begin
            w_i_ack_nxt   = 1'b1;
            w_i_rdata_nxt = w_resp_data;
          end
        end else begin
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_wait_cnt <= '0;
      r_m_en     <= 1'b0;
      r_i_ack    <= 1'b0;
      r_d_ack    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req      <= w_req_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_m_en     <= w_m_en_nxt;
      r_i_ack    <= w_i_ack_nxt;
      r_d_ack    <= w_d_ack_nxt;
      r_bus_err  <= w_bus_err_nxt;
      r_i_rdata  <= w_i_rdata_nxt;
      r_d_rdata  <= w_d_rdata_nxt;
    end
  end

  assign m_en    = r_m_en;
  assign m_we    = r_req.we;
  assign m_addr  = r_req.addr;
  assign m_wdata = r_req.wdata;
  assign i_ack   = r_i_ack;
  assign d_ack   = r_d_ack;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign bus_err = r_bus_err;

endmodule
